conv_mem_responder: RTL

// - Memory-side responder for the 3x3 convolution engine's read/write request interface.
// - Holds the 28x28 input image and the 26x26 result map.
// - Answers engine reads with 1-cycle registered data and commits byte-enabled engine writes.
// - Host side preloads the image, launches a run, collects the results and gets a completion interrupt.

---
 rtl/conv_mem_pkg.sv | 22 ++
 rtl/conv_word_ram.sv | 30 +++
 rtl/conv_mem_responder.sv | 113 +++++++++++
 3 files changed

// File: rtl/conv_mem_pkg.sv
// Shared constants, FSM state type and byte-address to word-index helper
// for the convolution engine memory responder.
package conv_mem_pkg;
   localparam int IMG_W     = 28;
   localparam int IMG_H     = 28;
   localparam int OUT_W     = IMG_W - 2;
   localparam int OUT_H     = IMG_H - 2;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int LANES     = DATA_W / 8;
   localparam int IMG_WORDS = IMG_W * IMG_H;
   localparam int RES_WORDS = OUT_W * OUT_H;
   localparam int IDX_W     = ADDR_W - 2;
   localparam int HOST_AW   = 10;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   // Byte lane bits are dropped; misaligned addresses simply alias the word.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:2];
   endfunction
endpackage

// File: rtl/conv_word_ram.sv
// Word RAM: one byte-enabled write port, one registered read-first read port.
// Read latency 1 cycle; rzero forces the read register to 0 instead of memory.
module conv_word_ram #(
   parameter int DEPTH = 784,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic          rzero,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   // Contents are deliberately not reset so data survives an aborted run.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= rzero ? '0 : mem[raddr];
   end
endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the 3x3 convolution engine: image and result RAMs,
// run FSM, range checking, write-beat counter and sticky error flag.
module conv_mem_responder
   import conv_mem_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                host_we,
   input  logic [HOST_AW-1:0]  host_addr,
   input  logic [DATA_W-1:0]   host_wdata,
   output logic [DATA_W-1:0]   host_rdata,
   input  logic                start,
   output logic                busy,
   output logic                irq,
   output logic                err,
   output logic [9:0]          wr_count,
   output logic                ready,
   input  logic                R_req,
   input  logic [ADDR_W-1:0]   R_addr,
   output logic [DATA_W-1:0]   R_data,
   input  logic [LANES-1:0]    W_req,
   input  logic [ADDR_W-1:0]   W_addr,
   input  logic [DATA_W-1:0]   W_data,
   input  logic                done
);
   localparam logic [IDX_W-1:0]   IMG_LIM  = IDX_W'(IMG_WORDS);
   localparam logic [IDX_W-1:0]   RES_LIM  = IDX_W'(RES_WORDS);
   localparam logic [HOST_AW-1:0] HIMG_LIM = HOST_AW'(IMG_WORDS);
   localparam logic [HOST_AW-1:0] HRES_LIM = HOST_AW'(RES_WORDS);
   localparam logic [9:0]         FULL_CNT = 10'(RES_WORDS);

   state_t             state;
   logic [IDX_W-1:0]   r_idx, w_idx;
   logic               r_in, w_in, w_beat, in_run, img_we, err_evt;
   logic [LANES-1:0]   res_be;
   logic [9:0]         wr_count_nxt;

   assign r_idx  = word_idx(R_addr);
   assign w_idx  = word_idx(W_addr);
   assign r_in   = r_idx < IMG_LIM;
   assign w_in   = w_idx < RES_LIM;
   assign w_beat = |W_req;
   assign in_run = (state == RUN);
   assign img_we = host_we && !in_run && (host_addr < HIMG_LIM);
   assign res_be = (in_run && w_in) ? W_req : '0;

   // Counting here lets a beat that coincides with done take part in the check.
   always_comb begin
      wr_count_nxt = wr_count;
      if (in_run && w_beat && wr_count != 10'h3FF) wr_count_nxt = wr_count + 10'd1;
   end

   assign err_evt = (R_req && !r_in)
                  | (w_beat && (!in_run || !w_in))
                  | (host_we && in_run)
                  | (in_run && done && wr_count_nxt != FULL_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready    <= 1'b0;
         busy     <= 1'b0;
         irq      <= 1'b0;
         err      <= 1'b0;
         wr_count <= '0;
      end else begin
         irq      <= 1'b0;
         wr_count <= wr_count_nxt;
         err      <= err | err_evt;
         case (state)
            IDLE: if (start) begin
               state    <= RUN;
               ready    <= 1'b1;
               busy     <= 1'b1;
               wr_count <= '0;
               err      <= err_evt;
            end
            RUN: if (done) begin
               state <= FIN;
               ready <= 1'b0;
               busy  <= 1'b0;
               irq   <= 1'b1;
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   conv_word_ram #(.DEPTH(IMG_WORDS), .AW(10)) u_img (
      .clk   (clk),
      .rst   (rst),
      .we    ({LANES{img_we}}),
      .waddr (host_addr),
      .wdata (host_wdata),
      .re    (R_req),
      .rzero (!r_in),
      .raddr (r_idx[9:0]),
      .rdata (R_data)
   );

   conv_word_ram #(.DEPTH(RES_WORDS), .AW(10)) u_res (
      .clk   (clk),
      .rst   (rst),
      .we    (res_be),
      .waddr (w_idx[9:0]),
      .wdata (W_data),
      .re    (1'b1),
      .rzero (host_addr >= HRES_LIM),
      .raddr (host_addr),
      .rdata (host_rdata)
   );
endmodule
